// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot accelerator host sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sequencer state enum, bus widths, accelerator pin-index constants.
package mandel_pkg;

    localparam int ITER_W = 7;
    localparam int BYTE_W = 8;

    // Bit positions on the accelerator pins: ui_in[2:0] and uo_out.
    localparam int PIN_START     = 0;
    localparam int PIN_LOAD_CR   = 1;
    localparam int PIN_LOAD_CI   = 2;
    localparam int PIN_UNBOUNDED = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CR,
        S_LOAD_CI,
        S_START,
        S_WAIT,
        S_RESP
    } state_e;

    // Counter widths must never collapse to zero bits.
    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/mandel_byte_serializer.sv
// Parallel-load shift register that emits a word MSB-first, one byte per cycle.
// Latency: first byte appears on byte_dat the cycle after load.
// Backpressure: none; the owner decides each cycle between load, shift or idle.
// Ports: clk/rst; load+load_dat start a word, shift advances one byte;
//        byte_dat is registered (0 when idle); last marks the final byte on byte_dat.
module mandel_byte_serializer
    import mandel_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_dat,
    input  logic              shift,
    output logic [7:0]        byte_dat,
    output logic              last
);

    localparam int NB    = WORD_W / BYTE_W;
    localparam int CNT_W = max1($clog2(NB));

    logic [WORD_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        byte_q;

    // The MSB byte goes straight to the output register on load, so sreg
    // only holds the bytes still to be sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg   <= '0;
            cnt    <= '0;
            byte_q <= '0;
        end else if (load) begin
            byte_q <= load_dat[WORD_W-1 -: BYTE_W];
            sreg   <= load_dat << BYTE_W;
            cnt    <= '0;
        end else if (shift) begin
            byte_q <= sreg[WORD_W-1 -: BYTE_W];
            sreg   <= sreg << BYTE_W;
            cnt    <= cnt + CNT_W'(1);
        end else begin
            // Bus must read zero whenever no load strobe is active.
            byte_q <= '0;
        end
    end

    assign byte_dat = byte_q;
    assign last     = (cnt == CNT_W'(NB - 1));

endmodule

// File: rtl/mandel_host_seq.sv
// Host sequencer: loads (Cr, Ci) byte-wise into the Mandelbrot accelerator, starts it, returns the result.
// Latency: request accept to rsp_valid = 2*B + 1 + (done WAIT cycle) + 2 cycles; all outputs registered.
// Backpressure: req_ready only in IDLE; rsp_* held until rsp_ready, no transaction overlap.
// Ports: req_valid/req_ready/req_cr/req_ci request; rsp_valid/rsp_ready/rsp_iter/rsp_unbounded/rsp_timeout
//        response; acc_start/acc_load_cr/acc_load_ci/acc_data drive ui_in[2:0]/uio_in, acc_unbounded/acc_iter
//        come from uo_out. Define MANDEL_SEQ_TIMEOUT_EN to build the WAIT timeout counter.
module mandel_host_seq
    import mandel_pkg::*;
#(
    parameter int COORD_W  = 16,
    parameter int MAX_ITER = 100,
    parameter int HOLDOFF  = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_cr,
    input  logic [COORD_W-1:0] req_ci,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [6:0]         rsp_iter,
    output logic               rsp_unbounded,
    output logic               rsp_timeout,
    output logic               acc_start,
    output logic               acc_load_cr,
    output logic               acc_load_ci,
    output logic [7:0]         acc_data,
    input  logic               acc_unbounded,
    input  logic [6:0]         acc_iter
);

    // Saturating holdoff counter; one extra code so HOLDOFF=0 still has a bit.
    localparam int HCNT_W = $clog2(HOLDOFF + 2);

    state_e state, state_n;

    logic [COORD_W-1:0] ci_q;
    logic               ser_load;
    logic               ser_shift;
    logic [COORD_W-1:0] ser_dat;
    logic [7:0]         ser_byte;
    logic               ser_last;

    logic [2:0]         strobe_n;
    logic [2:0]         strobe_q;

    logic [HCNT_W-1:0]  hold_cnt;
    logic               holdoff_done;

    logic [BYTE_W-1:0]  uo;
    logic               unb_in;
    logic [ITER_W-1:0]  iter_in;
    logic               done;
    logic               to_hit;

    logic               rsp_valid_q;
    logic [ITER_W-1:0]  rsp_iter_q;
    logic               rsp_unb_q;

    // Reassemble the accelerator's uo_out so the pin map lives in one place.
    assign uo      = {acc_iter, acc_unbounded};
    assign unb_in  = uo[PIN_UNBOUNDED];
    assign iter_in = uo[BYTE_W-1:1];

    assign holdoff_done = (hold_cnt == HCNT_W'(HOLDOFF));
    // Escape and budget exhaustion are both terminal; escape wins the flag.
    assign done = holdoff_done && (unb_in || (iter_in >= ITER_W'(MAX_ITER)));

`ifdef MANDEL_SEQ_TIMEOUT_EN
    localparam int TCNT_W = max1($clog2(TIMEOUT));

    logic [TCNT_W-1:0] to_cnt;
    logic              rsp_to_q;

    assign to_hit = (to_cnt == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt   <= '0;
            rsp_to_q <= 1'b0;
        end else begin
            if (state == S_START) begin
                to_cnt <= '0;
            end else if (state == S_WAIT) begin
                to_cnt <= to_cnt + TCNT_W'(1);
            end
            if (state == S_WAIT && (done || to_hit)) begin
                rsp_to_q <= !done;
            end
        end
    end

    assign rsp_timeout = rsp_to_q;
`else
    // TIMEOUT only matters when the timeout counter is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT;

    assign to_hit      = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    mandel_byte_serializer #(
        .WORD_W (COORD_W)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .load_dat (ser_dat),
        .shift    (ser_shift),
        .byte_dat (ser_byte),
        .last     (ser_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Strobes and data are registered from the next state so the pins change
    // on the same edge as the state they belong to.
    always_comb begin
        state_n   = state;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        ser_dat   = req_cr;
        strobe_n  = '0;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    ser_load = 1'b1;
                    ser_dat  = req_cr;
                    state_n  = S_LOAD_CR;
                end
            end
            S_LOAD_CR: begin
                if (ser_last) begin
                    // Reload with Ci so its MSB byte follows Cr's LSB byte back-to-back.
                    ser_load = 1'b1;
                    ser_dat  = ci_q;
                    state_n  = S_LOAD_CI;
                end else begin
                    ser_shift = 1'b1;
                end
            end
            S_LOAD_CI: begin
                if (ser_last) begin
                    state_n = S_START;
                end else begin
                    ser_shift = 1'b1;
                end
            end
            S_START: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (done || to_hit) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        strobe_n[PIN_START]   = (state_n == S_START);
        strobe_n[PIN_LOAD_CR] = (state_n == S_LOAD_CR);
        strobe_n[PIN_LOAD_CI] = (state_n == S_LOAD_CI);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q    <= '0;
            ci_q        <= '0;
            hold_cnt    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_iter_q  <= '0;
            rsp_unb_q   <= 1'b0;
        end else begin
            strobe_q    <= strobe_n;
            rsp_valid_q <= (state_n == S_RESP);

            if (state == S_IDLE && req_valid) begin
                ci_q <= req_ci;
            end

            if (state == S_START) begin
                hold_cnt <= '0;
            end else if (state == S_WAIT && !holdoff_done) begin
                hold_cnt <= hold_cnt + HCNT_W'(1);
            end

            if (state == S_WAIT && (done || to_hit)) begin
                rsp_iter_q <= iter_in;
                // A timeout never reports escape, even if the flag glitched in holdoff.
                rsp_unb_q  <= done && unb_in;
            end
        end
    end

    assign req_ready     = (state == S_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_iter      = rsp_iter_q;
    assign rsp_unbounded = rsp_unb_q;
    assign acc_start     = strobe_q[PIN_START];
    assign acc_load_cr   = strobe_q[PIN_LOAD_CR];
    assign acc_load_ci   = strobe_q[PIN_LOAD_CI];
    assign acc_data      = ser_byte;

endmodule

// File: doc/mandel_host_seq.md
# mandel_host_seq

Host-side sequencer for the Mandelbrot accelerator's pin protocol. It accepts one complex point (Cr, Ci) over a valid/ready request port and serialises both coordinates byte-wise onto the accelerator's 8-bit data bus using the load strobes. It then pulses start, monitors the accelerator's unbounded/iteration outputs until the point resolves, and returns the result on a valid/ready response port. It sits between a pixel-generation or readout engine and the accelerator pins (ui_in[2:0], uio_in, uo_out).

## Interface
Parameters:
- COORD_W, 16: coordinate width in bits; must be a multiple of 8. Bytes per coordinate are B = COORD_W/8.
- MAX_ITER, 100: iteration budget; the point is declared bounded when acc_iter >= MAX_ITER. Range 1..127.
- HOLDOFF, 2: cycles after the start pulse during which accelerator outputs are ignored.
- TIMEOUT, 1024: WAIT-state cycle limit. Used only with the timeout feature.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req_valid, in, 1: request valid.
- req_ready, out, 1: request ready; high only in IDLE.
- req_cr, in, COORD_W: real part, two's complement.
- req_ci, in, COORD_W: imaginary part, two's complement.
- rsp_valid, out, 1: result valid.
- rsp_ready, in, 1: result accepted.
- rsp_iter, out, 7: captured iteration count.
- rsp_unbounded, out, 1: point escaped.
- rsp_timeout, out, 1: WAIT aborted by timeout.
- acc_start, out, 1: start strobe to the accelerator (ui_in[0]).
- acc_load_cr, out, 1: Cr byte strobe (ui_in[1]).
- acc_load_ci, out, 1: Ci byte strobe (ui_in[2]).
- acc_data, out, 8: byte bus to the accelerator (uio_in).
- acc_unbounded, in, 1: accelerator escape flag (uo_out[0]).
- acc_iter, in, 7: accelerator iteration count (uo_out[7:1]).

## Operation
- FSM states: IDLE, LOAD_CR, LOAD_CI, START, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch Cr and Ci and go to LOAD_CR.
- LOAD_CR:
  - B cycles with acc_load_cr=1.
  - acc_data carries Cr MSB-first, one byte per cycle.
  - Then go to LOAD_CI.
- LOAD_CI:
  - Same as LOAD_CR, for Ci with acc_load_ci=1.
  - Then go to START.
- START:
  - One cycle with acc_start=1 and acc_data=0.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - For the first HOLDOFF cycles, acc_* inputs are ignored.
  - After holdoff, done when acc_unbounded=1 or acc_iter>=MAX_ITER.
  - On done, capture rsp_iter=acc_iter and rsp_unbounded=acc_unbounded, then go to RESP.
  - If both conditions hold in the same cycle, rsp_unbounded=1 and rsp_iter is the value seen.
- RESP:
  - rsp_valid=1; rsp_* are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - A pending request is not accepted in the RESP cycle; there is no overlap of transactions.
- Strobe rules:
  - At most one of acc_start/acc_load_cr/acc_load_ci is high in any cycle.
  - acc_data=0 whenever no load strobe is high.
- Reset values: state=IDLE, req_ready=1 (combinational from state), rsp_valid=0, rsp_iter=0, rsp_unbounded=0, rsp_timeout=0, all acc_* outputs 0.
- Reset mid-operation:
  - Strobes drop immediately (asynchronous).
  - Any partially loaded point and any pending response are discarded.
  - The accelerator is re-initialised by the next full load.

## Timing
- Accept at edge 0. LOAD_CR occupies cycles 1..B, LOAD_CI cycles B+1..2B, START cycle 2B+1.
- For COORD_W=16: Cr bytes in cycles 1-2, Ci bytes in cycles 3-4, start in cycle 5, WAIT from cycle 6.
- Done is detected no earlier than WAIT cycle HOLDOFF. rsp_valid rises on the next edge.
- All acc_* and rsp_* outputs are registered; no combinational path from acc_* to rsp_*.
- Request-to-request minimum: 2B+HOLDOFF+4 cycles with rsp_ready held high.

## Configuration
- MANDEL_SEQ_TIMEOUT_EN defined:
  - A clog2(TIMEOUT)-bit counter runs in WAIT.
  - When the counter reaches TIMEOUT-1 without done, go to RESP with rsp_timeout=1, rsp_unbounded=0 and rsp_iter=acc_iter.
- Undefined:
  - No counter is built; rsp_timeout is tied to 0.
  - WAIT persists until done or reset.

## Structure
- Package mandel_pkg holds:
  - the state enum;
  - ITER_W=7 and BYTE_W=8;
  - the acc pin-index constants (START=0, LOAD_CR=1, LOAD_CI=2, UNBOUNDED=0).
- Sub-module mandel_byte_serializer:
  - parallel-load shift register with byte counter;
  - emits MSB-first bytes and a last-byte flag;
  - instantiated once and reloaded with Ci at the LOAD_CR→LOAD_CI boundary.

## Test plan
- Reset then Cr=16'h1234, Ci=16'hABCD with rsp_ready=1 -> bytes 12,34 with load_cr in cycles 1-2; AB,CD with load_ci in cycles 3-4; start only in cycle 5.
- Model drives acc_unbounded=1, acc_iter=17 at WAIT cycle 4 -> rsp_valid next cycle with rsp_iter=17, rsp_unbounded=1, rsp_timeout=0.
- Model ramps acc_iter to 100 with unbounded=0; a glitch of unbounded=1 during holdoff -> glitch ignored; rsp_iter=100, rsp_unbounded=0.
- rsp_ready held 0 for 10 cycles -> rsp_* stable, req_ready=0; new request accepted the cycle after the handshake.
- rst asserted in LOAD_CI cycle 3 -> all acc_* outputs 0 immediately, rsp_valid=0, req_ready=1 after release.
- MANDEL_SEQ_TIMEOUT_EN, TIMEOUT=16, model never finishes with acc_iter=5 -> rsp_timeout=1, rsp_iter=5 after 16 WAIT cycles. Without the macro, no response after 1000 cycles.
